banked_dp_ram: RTL and testbench



---
 rtl/banked_dp_ram_pkg.sv | 21 ++
 rtl/banked_dp_ram_bank.sv | 32 +++
 rtl/banked_dp_ram.sv | 132 +++++++++++++
 tb/tb_banked_dp_ram.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_dp_ram_pkg.sv
// Shared constants and address helpers for the banked dual-port RAM.
// Ports are numbered 0/1. Words are interleaved across the banks by their low-order bits.
package banked_dp_ram_pkg;

    localparam int PORT0     = 0;
    localparam int PORT1     = 1;
    localparam int NUM_PORTS = 2;

    // Bank that holds a word under low-order interleaving.
    function automatic int unsigned bank_of(input int unsigned word,
                                            input int unsigned nbanks);
        return word % nbanks;
    endfunction

    // Row of a word inside its bank.
    function automatic int unsigned row_of(input int unsigned word,
                                           input int unsigned nbanks);
        return word / nbanks;
    endfunction

endpackage

// File: rtl/banked_dp_ram_bank.sv
// One single-port storage bank with byte enables and a registered read.
// The bank has no reset, so stored data survives a reset of the top level.
module ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 128,
    parameter int ROW_W      = 7
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [ROW_W-1:0]        row_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem [ROWS];

    // Byte-masked write, or a read that is captured for the next cycle.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < DATA_WIDTH/8; i++) begin
                    if (be_i[i]) mem[row_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end else begin
                rdata_o <= mem[row_i];
            end
        end
    end

endmodule

// File: rtl/banked_dp_ram.sv
// Two-port banked scratchpad. Each bank resolves a conflict with a round-robin priority bit.
// Reads return one cycle after the grant. Out-of-range accesses are granted, but a write is dropped and a read returns zero.
module banked_dp_ram
    import banked_dp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 1024,
    parameter int NUM_BANKS  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [1:0]                   req_i,
    output logic [1:0]                   gnt_o,
    input  logic [1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [1:0]                   we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [1:0][DATA_WIDTH-1:0]   wdata_i,
    output logic [1:0]                   rvalid_o,
    output logic [1:0][DATA_WIDTH-1:0]   rdata_o
);

    localparam int          BYTES  = DATA_WIDTH / 8;
    localparam int          OFF    = $clog2(BYTES);
    localparam int          WORD_W = ADDR_WIDTH - OFF;
    localparam int unsigned WORDS  = NUM_BYTES / BYTES;
    localparam int          ROWS   = WORDS / NUM_BANKS;
    localparam int          BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int          ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [NUM_PORTS-1:0][WORD_W-1:0] word;
    logic [NUM_PORTS-1:0][BANK_W-1:0] bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]  row;
    logic [NUM_PORTS-1:0]             in_rng;
    logic                             conflict;
    logic [NUM_BANKS-1:0]             prio;

    logic [NUM_BANKS-1:0]                 b_sel;
    logic [NUM_BANKS-1:0]                 b_en;
    logic [NUM_BANKS-1:0]                 b_we;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] b_rdata;

    logic [NUM_PORTS-1:0]                 rvalid_q;
    logic [NUM_PORTS-1:0]                 oor_q;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     bank_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] hold_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, addr_i[PORT0][OFF-1:0], addr_i[PORT1][OFF-1:0]};

    // Split each byte address into word, bank, row and a range flag.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            word[p]   = addr_i[p][ADDR_WIDTH-1:OFF];
            bank[p]   = BANK_W'(bank_of(32'(word[p]), NUM_BANKS));
            row[p]    = ROW_W'(row_of(32'(word[p]), NUM_BANKS));
            in_rng[p] = 32'(word[p]) < WORDS;
        end
    end

    // Grant both ports unless they collide on a bank; that bank's priority bit then picks the winner.
    always_comb begin
        conflict = req_i[PORT0] & req_i[PORT1] & (bank[PORT0] == bank[PORT1]);
        gnt_o[PORT0] = ~rst_i & req_i[PORT0] & (~conflict | ~prio[bank[PORT0]]);
        gnt_o[PORT1] = ~rst_i & req_i[PORT1] & (~conflict | prio[bank[PORT1]]);
    end

    // After a conflict the bank favours the port that lost it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio <= '0;
        end else if (conflict) begin
            prio[bank[PORT0]] <= ~prio[bank[PORT0]];
        end
    end

    // Route the granted port of each bank onto its storage; out-of-range writes are dropped.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            b_sel[b] = gnt_o[PORT1] && (bank[PORT1] == BANK_W'(b));
            b_en[b]  = b_sel[b] ||
                       (gnt_o[PORT0] && (bank[PORT0] == BANK_W'(b)));
            b_we[b]  = we_i[b_sel[b]] & in_rng[b_sel[b]];
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ROWS      (ROWS),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clk_i  (clk_i),
            .en_i   (b_en[g]),
            .we_i   (b_we[g]),
            .row_i  (row[b_sel[g]]),
            .be_i   (be_i[b_sel[g]]),
            .wdata_i(wdata_i[b_sel[g]]),
            .rdata_o(b_rdata[g])
        );
    end

    // Remember which bank each granted read went to, and hold the last returned word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            oor_q    <= '0;
            bank_q   <= '0;
            hold_q   <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rvalid_q[p] <= gnt_o[p] & ~we_i[p];
                if (gnt_o[p] & ~we_i[p]) begin
                    bank_q[p] <= bank[p];
                    oor_q[p]  <= ~in_rng[p];
                end
                hold_q[p] <= rdata_o[p];
            end
        end
    end

    // Return bank data (or zero if out of range) on valid, otherwise the held word.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata_o[p] = hold_q[p];
            if (rvalid_q[p]) rdata_o[p] = oor_q[p] ? '0 : b_rdata[bank_q[p]];
            if (rst_i) rdata_o[p] = '0;
        end
        rvalid_o = rvalid_q & ~{NUM_PORTS{rst_i}};
    end

endmodule

// File: tb/tb_banked_dp_ram.sv
// Bench for banked_dp_ram: a table of directed vectors, a reset sequence
// and a randomized run against a word-array reference model.
module tb_banked_dp_ram;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int NBYTES = 512;
    localparam int NBANKS = 2;
    localparam int WORDS  = NBYTES / (DW / 8);

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0][AW-1:0]  addr;
    logic [1:0]          we;
    logic [1:0][3:0]     be;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0]          rvalid;
    logic [1:0][DW-1:0]  rdata;

    always #5 clk = ~clk;

    banked_dp_ram #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_BYTES (NBYTES),
        .NUM_BANKS (NBANKS)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .be_i    (be),
        .wdata_i (wdata),
        .rvalid_o(rvalid),
        .rdata_o (rdata)
    );

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic [AW-1:0] a0;
        logic [31:0]   d0;
        logic [3:0]    be0;
        logic [AW-1:0] a1;
        logic [31:0]   d1;
        logic [3:0]    be1;
        logic [1:0]    gnt;
        logic [1:0]    rv;
        logic [31:0]   r0;
        logic [31:0]   r1;
    } vec_t;

    function automatic vec_t mk(
        input logic [1:0] rq, input logic [1:0] w,
        input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] b0,
        input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] b1,
        input logic [1:0] g, input logic [1:0] rv,
        input logic [31:0] r0, input logic [31:0] r1);
        vec_t v;
        v.req = rq; v.we = w;
        v.a0 = a0; v.d0 = d0; v.be0 = b0;
        v.a1 = a1; v.d1 = d1; v.be1 = b1;
        v.gnt = g; v.rv = rv; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req = v.req; we = v.we;
        addr[0] = v.a0; wdata[0] = v.d0; be[0] = v.be0;
        addr[1] = v.a1; wdata[1] = v.d1; be[1] = v.be1;
    endtask

    task automatic idle();
        req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[21];

    logic [31:0] mem_m [WORDS];
    bit          prio_m [NBANKS];
    logic [1:0]  erv;
    logic [31:0] erd [2];
    logic [1:0]  eg;
    logic [1:0]  pend;
    int          w    [2];
    int          bk   [2];
    bit          conf;

    initial begin
        // Directed vectors: basic, partial write, parallel, conflict, out of range.
        tbl[0]  = mk(2'b01, 2'b01, 10'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[1]  = mk(2'b01, 2'b00, 10'h010, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[2]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF, 0);
        tbl[3]  = mk(2'b01, 2'b01, 10'h010, 32'h11223344, 4'b0101, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[4]  = mk(2'b01, 2'b00, 10'h010, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[5]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 32'hDE22BE44, 0);
        tbl[6]  = mk(2'b11, 2'b11, 10'h000, 32'hA5A5A5A5, 4'hF, 10'h004, 32'hCAFEF00D, 4'hF, 2'b11, 2'b00, 0, 0);
        tbl[7]  = mk(2'b11, 2'b10, 10'h000, 0, 0, 10'h004, 32'h12345678, 4'hF, 2'b11, 2'b00, 0, 0);
        tbl[8]  = mk(2'b10, 2'b00, 0, 0, 0, 10'h004, 0, 0, 2'b10, 2'b01, 32'hA5A5A5A5, 0);
        tbl[9]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 32'h12345678);
        tbl[10] = mk(2'b01, 2'b01, 10'h008, 32'h0BADCAFE, 4'hF, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[11] = mk(2'b11, 2'b00, 10'h000, 0, 0, 10'h008, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[12] = mk(2'b11, 2'b00, 10'h000, 0, 0, 10'h008, 0, 0, 2'b10, 2'b01, 32'hA5A5A5A5, 0);
        tbl[13] = mk(2'b11, 2'b00, 10'h000, 0, 0, 10'h008, 0, 0, 2'b01, 2'b10, 0, 32'h0BADCAFE);
        tbl[14] = mk(2'b11, 2'b00, 10'h000, 0, 0, 10'h008, 0, 0, 2'b10, 2'b01, 32'hA5A5A5A5, 0);
        tbl[15] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 32'h0BADCAFE);
        tbl[16] = mk(2'b01, 2'b01, 10'h100, 32'h77777777, 4'hF, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[17] = mk(2'b10, 2'b10, 0, 0, 0, 10'h300, 32'hFFFFFFFF, 4'hF, 2'b10, 2'b00, 0, 0);
        tbl[18] = mk(2'b11, 2'b00, 10'h100, 0, 0, 10'h300, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[19] = mk(2'b10, 2'b00, 0, 0, 0, 10'h300, 0, 0, 2'b10, 2'b01, 32'h77777777, 0);
        tbl[20] = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);

        // Reset holds grants, valids and data at zero even with requests pending.
        rst = 1'b1;
        idle();
        req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("reset gnt", 32'(gnt), 0);
            chk("reset rvalid", 32'(rvalid), 0);
            chk("reset rdata0", rdata[0], 0);
            chk("reset rdata1", rdata[1], 0);
            step();
        end
        rst = 1'b0;
        idle();

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            if (tbl[i].rv[0]) chk($sformatf("v%0d rdata0", i), rdata[0], tbl[i].r0);
            if (tbl[i].rv[1]) chk($sformatf("v%0d rdata1", i), rdata[1], tbl[i].r1);
            step();
        end

        // A read granted just before reset gives no rvalid; reset clears priority but not memory.
        idle();
        req = 2'b01; addr[0] = 10'h010;
        @(negedge clk);
        chk("pre-reset gnt", 32'(gnt), 32'h1);
        step();
        rst = 1'b1;
        idle();
        @(negedge clk);
        chk("cut rvalid", 32'(rvalid), 0);
        chk("cut rdata0", rdata[0], 0);
        step();
        rst = 1'b0;
        req = 2'b11; addr[0] = 10'h000; addr[1] = 10'h008;
        @(negedge clk);
        chk("post-reset prio gnt", 32'(gnt), 32'h1);
        chk("post-reset rvalid", 32'(rvalid), 0);
        step();
        addr[0] = 10'h004;
        @(negedge clk);
        chk("held req gnt", 32'(gnt), 32'h3);
        chk("held req rvalid", 32'(rvalid), 32'h1);
        chk("held req rdata0", rdata[0], 32'hA5A5A5A5);
        step();
        req = 2'b01; addr[0] = 10'h010;
        @(negedge clk);
        chk("survive gnt", 32'(gnt), 32'h1);
        chk("survive rvalid", 32'(rvalid), 32'h3);
        chk("survive rdata0", rdata[0], 32'h12345678);
        chk("survive rdata1", rdata[1], 32'h0BADCAFE);
        step();
        idle();
        @(negedge clk);
        chk("survive data", rdata[0], 32'hDE22BE44);
        chk("rdata1 hold", rdata[1], 32'h0BADCAFE);
        chk("survive rvalid2", 32'(rvalid), 32'h1);
        step();

        // Randomized run against the reference model, starting from a fresh reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < NBANKS; i++) prio_m[i] = 1'b0;
        for (int i = 0; i < WORDS; i++) begin
            idle();
            req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF;
            addr[0] = AW'(i * 4);
            wdata[0] = $urandom;
            mem_m[i] = wdata[0];
            @(negedge clk);
            chk($sformatf("init %0d gnt", i), 32'(gnt), 32'h1);
            step();
        end
        idle();
        erv = '0;
        erd[0] = '0; erd[1] = '0;
        pend = '0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    req[p]   = ($urandom_range(3) != 0);
                    addr[p]  = AW'($urandom_range(1023));
                    we[p]    = 1'($urandom_range(1));
                    be[p]    = 4'($urandom_range(15));
                    wdata[p] = $urandom;
                end
                w[p]  = int'(addr[p]) / 4;
                bk[p] = w[p] % NBANKS;
            end
            conf  = req[0] && req[1] && (bk[0] == bk[1]);
            eg[0] = req[0] && (!conf || !prio_m[bk[0]]);
            eg[1] = req[1] && (!conf || prio_m[bk[1]]);
            @(negedge clk);
            chk($sformatf("rnd %0d gnt", c), 32'(gnt), 32'(eg));
            chk($sformatf("rnd %0d rvalid", c), 32'(rvalid), 32'(erv));
            for (int p = 0; p < 2; p++) begin
                if (erv[p]) chk($sformatf("rnd %0d rdata%0d", c, p), rdata[p], erd[p]);
            end
            for (int p = 0; p < 2; p++) begin
                erv[p] = eg[p] && !we[p];
                if (erv[p]) erd[p] = (w[p] < WORDS) ? mem_m[w[p]] : 32'h0;
            end
            for (int p = 0; p < 2; p++) begin
                if (eg[p] && we[p] && w[p] < WORDS) begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[p][k]) mem_m[w[p]][8*k +: 8] = wdata[p][8*k +: 8];
                    end
                end
            end
            if (conf) prio_m[bk[0]] = !prio_m[bk[0]];
            pend = req & ~eg;
            step();
        end
        idle();
        @(negedge clk);
        chk("drain rvalid", 32'(rvalid), 32'(erv));
        for (int p = 0; p < 2; p++) begin
            if (erv[p]) chk($sformatf("drain rdata%0d", p), rdata[p], erd[p]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
